// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every input vector of an N_IN-input combinational
// block, holds it HOLD_CYCLES cycles, samples dut_f and checks it against EXP_TABLE.
module truth_table_sweeper #(
    parameter int unsigned             N_IN        = 3,
    parameter int unsigned             HOLD_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]    EXP_TABLE   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_f,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   ERR_ONE   = {{N_IN{1'b0}}, 1'b1};
    localparam logic [7:0]      HOLD_LOAD = 8'(HOLD_CYCLES);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      hold_q, hold_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fev_q, fev_d;
    logic            fval_q, fval_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fval_d  = fval_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    hold_d  = HOLD_LOAD;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fev_d   = '0;
                    fval_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                end else begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // abort wins over the compare: the pending sample is dropped
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                end else begin
                    if (dut_f != EXP_TABLE[vec_q]) begin
                        err_d = err_q + ERR_ONE;
                        if (!fval_q) begin
                            fev_d  = vec_q;
                            fval_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_DRIVE;
                        vec_d   = vec_q + VEC_ONE;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fval_q  <= fval_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fval_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus queues expected sweep results, monitors check them on done.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 3 inputs, hold 1
    logic       start_a = 1'b0, abort_a = 1'b0, f_a;
    logic [2:0] vec_a, fev_a;
    logic [3:0] err_a;
    logic       busy_a, done_a, pass_a, fval_a;
    logic [7:0] exp_a = 8'b1001_0110;
    int         mode_a = 0;

    // DUT B: 4 inputs, hold 3, model inverted vs table
    logic        start_b = 1'b0, abort_b = 1'b0, f_b;
    logic [3:0]  vec_b, fev_b;
    logic [4:0]  err_b;
    logic        busy_b, done_b, pass_b, fval_b;
    logic [15:0] exp_b = 16'hA5C3;

    always_comb begin
        f_a = exp_a[vec_a];
        case (mode_a)
            1:       f_a = 1'b0;
            2:       f_a = exp_a[vec_a] ^ ((vec_a == 3'd2) || (vec_a == 3'd5));
            default: f_a = exp_a[vec_a];
        endcase
        f_b = ~exp_b[vec_b];
    end

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1), .EXP_TABLE(8'b1001_0110)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_f(f_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_vec(fev_a), .first_err_valid(fval_a));

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(3), .EXP_TABLE(16'hA5C3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_f(f_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_vec(fev_b), .first_err_valid(fval_b));

    typedef struct {
        int err;
        int fev;
        int fval;
        int pass;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_a(input int err, input int fev, input int fval, input int pass, input int dcyc);
        exp_t e;
        e.err = err; e.fev = fev; e.fval = fval; e.pass = pass; e.cyc = dcyc;
        q_a.push_back(e);
    endtask

    // Monitor A
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done_a) begin
            if (q_a.size() == 0) begin
                check("unexpected_done_a", 1, 0);
            end else begin
                e = q_a.pop_front();
                check("a_err_count", int'(err_a), e.err);
                check("a_first_err_vec", int'(fev_a), e.fev);
                check("a_first_err_valid", int'(fval_a), e.fval);
                check("a_pass", int'(pass_a), e.pass);
                check("a_done_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor B
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done_b) begin
            if (q_b.size() == 0) begin
                check("unexpected_done_b", 1, 0);
            end else begin
                e = q_b.pop_front();
                check("b_err_count", int'(err_b), e.err);
                check("b_first_err_vec", int'(fev_b), e.fev);
                check("b_first_err_valid", int'(fval_b), e.fval);
                check("b_pass", int'(pass_b), e.pass);
                check("b_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain;
        for (int i = 0; i < 400; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", q_a.size() + q_b.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_vec"}, int'(vec_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_pass"}, int'(pass_a), 0);
        check({tag, "_err"}, int'(err_a), 0);
        check({tag, "_fev"}, int'(fev_a), 0);
        check({tag, "_fval"}, int'(fval_a), 0);
    endtask

    initial begin
        #2;
        check_reset_a("rst_a");
        check("rst_b_err", int'(err_b), 0);
        check("rst_b_busy", int'(busy_b), 0);
        #15 rst_n = 1'b1;

        // Sweep 1: matching model, vector stepping and pass
        @(posedge clk); #1;
        mode_a = 0;
        start_a = 1'b1;
        push_a(0, 0, 0, 1, cyc + 1 + 16);
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("a_vec_step", int'(vec_a), k >> 1);
            check("a_busy_sweep", int'(busy_a), 1);
        end
        drain();
        check("a_pass_hold", int'(pass_a), 1);

        // Sweep 2: stuck-at-0 model
        @(posedge clk); #1;
        mode_a = 1;
        start_a = 1'b1;
        push_a(4, 1, 1, 0, cyc + 1 + 16);
        @(posedge clk); #1;
        start_a = 1'b0;
        drain();
        check("a_err_hold", int'(err_a), 4);

        // Sweep 3: wide DUT, every vector wrong, no counter wrap
        @(posedge clk); #1;
        begin
            exp_t e;
            e.err = 16; e.fev = 0; e.fval = 1; e.pass = 0; e.cyc = cyc + 1 + 64;
            q_b.push_back(e);
        end
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        drain();

        // Abort in SAMPLE of vector 5; mismatches planted at vectors 2 and 5
        @(posedge clk); #1;
        mode_a = 2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("abort_vec", int'(vec_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_err", int'(err_a), 1);
        check("abort_fev", int'(fev_a), 2);
        check("abort_fval", int'(fval_a), 1);
        check("abort_pass", int'(pass_a), 0);
        repeat (6) @(negedge clk);
        check("abort_stays_idle", int'(busy_a), 0);

        // Start held high through DONE: back-to-back sweeps, busy-time start ignored
        @(posedge clk); #1;
        mode_a = 1;
        start_a = 1'b1;
        push_a(4, 1, 1, 0, cyc + 1 + 16);
        push_a(4, 1, 1, 0, cyc + 34);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a) break;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        check("b2b_busy", int'(busy_a), 1);
        check("b2b_err_cleared", int'(err_a), 0);
        check("b2b_fval_cleared", int'(fval_a), 0);
        check("b2b_vec", int'(vec_a), 0);
        drain();

        // Asynchronous reset mid-DRIVE
        @(posedge clk); #1;
        mode_a = 1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_err", int'(err_a), 1);
        check("pre_reset_vec", int'(vec_a), 2);
        #1 rst_n = 1'b0;
        #1;
        check_reset_a("async_rst");
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", int'(busy_a), 0);
        check("post_reset_vec", int'(vec_a), 0);

        // Fresh sweep after reset
        @(posedge clk); #1;
        mode_a = 0;
        start_a = 1'b1;
        push_a(0, 0, 0, 1, cyc + 1 + 16);
        @(posedge clk); #1;
        start_a = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential exhaustive-stimulus engine for an N-input, 1-output combinational DUT.
- Drives every input vector 0..2^N_IN-1 in order, holds each for a programmable settle time, and samples the DUT output.
- Compares each sample against a parameterised expected truth table, counts mismatches and records the first failing vector.
- Sits between a controller (start/abort) and the combinational block under test. It replaces hand-written per-vector stimulus and generalises the fixed 3-input sweep to any width and settle time.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- HOLD_CYCLES, 1, settle cycles each vector is driven before sampling; legal range 1..255.
- EXP_TABLE, 8'b0000_0000, 2^N_IN-bit expected output; bit k is the expected f for input vector k.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel of an active sweep.
- dut_f  in  1  DUT output to be checked.
- vec_out  out  N_IN  input vector driven to the DUT.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  single-cycle pulse when a sweep completes.
- pass  out  1  high when the last completed sweep had err_count==0.
- err_count  out  N_IN+1  mismatches seen in the current or last sweep.
- first_err_vec  out  N_IN  vector of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a valid vector.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, hold counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1: go to DRIVE.
  - Same edge: vec_out=0, err_count=0, first_err_valid=0, first_err_vec=0, pass=0, hold counter loaded.
- DRIVE: stays exactly HOLD_CYCLES cycles with vec_out stable, then goes to SAMPLE.
- SAMPLE (1 cycle): compare dut_f with EXP_TABLE[vec_out].
  - On mismatch: err_count += 1. If first_err_valid=0, set first_err_vec=vec_out and first_err_valid=1.
  - If vec_out == 2^N_IN-1: go to DONE, vec_out unchanged.
  - Otherwise: vec_out += 1 and return to DRIVE with the hold counter reloaded.
- DONE (1 cycle): done=1, pass=(err_count==0), then go to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving a back-to-back sweep with no idle cycle.
- Latency: per vector HOLD_CYCLES+1 cycles. done is high in the cycle beginning 2^N_IN*(HOLD_CYCLES+1) edges after the start-accepting edge. For defaults this is 16.
- busy=1 exactly in DRIVE and SAMPLE. start while busy is ignored.
- abort=1 in DRIVE or SAMPLE: next state IDLE.
  - vec_out=0.
  - done is not pulsed and pass stays 0.
  - err_count and first_err_* are frozen at their current values.
- abort has priority over the SAMPLE compare in the same cycle; that sample is discarded. abort in IDLE or DONE is ignored.
- err_count never wraps: width N_IN+1 holds a maximum of 2^N_IN.
- pass, err_count and first_err_* hold their values after DONE until the next accepted start or reset.
- Reset asserted mid-sweep: immediate return to the reset values above; no done pulse.
- dut_f is sampled only in SAMPLE; its value in all other states is don't-care.

Test Plan:
- Defaults, DUT model f = EXP_TABLE[vec] (EXP_TABLE=8'b1001_0110): one start pulse -> vec_out steps 0..7, each held 2 cycles; done pulse 16 cycles after start; pass=1, err_count=0, first_err_valid=0.
- EXP_TABLE=8'b1001_0110, DUT output stuck at 0 -> err_count=4, first_err_vec=3'd1, first_err_valid=1, pass=0.
- N_IN=4, HOLD_CYCLES=3, DUT inverted vs table -> err_count=16 (5'b10000, no wrap), first_err_vec=0, done 64 cycles after start.
- abort asserted in the SAMPLE cycle of vector 5, one mismatch already at vector 2 -> IDLE next cycle, vec_out=0, no done, err_count=1, first_err_vec=2, pass=0; vector 5 not counted.
- start held high through DONE -> second sweep begins on the edge leaving DONE; err_count cleared to 0; start pulses during busy produce no restart.
- rst_n driven low asynchronously mid-DRIVE (between clock edges) -> all outputs at reset values immediately, before the next edge; sweep resumes only on a new start.
